conv_deinterleaver: RTL
=======================

Name: conv_deinterleaver

Overview:
- Byte-wide convolutional (Forney) deinterleaver; receive-side counterpart of the interleaver built from chained 8-bit delay stages.
- Commutator steps through I branches; branch j delays bytes by (I-1-j)*M visits, so that branch depth plus the interleaver's j*M gives a constant (I-1)*M on every path.
- All branch FIFOs share one circular-buffer RAM; a clear FSM zero-fills it after reset.
- Sits between the demodulator byte stream and the outer RS decoder.

Parameters:
- I, 12, number of branches.
- M, 17, depth unit in bytes; branch j depth = (I-1-j)*M.
- W, 8, data width.
- DEPTH, M*I*(I-1)/2 (1122), total RAM cells; derived, not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input byte present.
- in_ready  out  1  block accepts input; 0 during CLEAR.
- in_data  in  W  interleaved byte.
- in_sync  in  1  marks first byte of a packet; that byte must fall on branch 0.
- out_valid  out  1  out_data valid, one-cycle pulse per accepted byte.
- out_data  out  W  deinterleaved byte.
- sync_err  out  1  one-cycle pulse when a commutator realignment happens.

Behaviour:
- Reset (sync, active-high): state=CLEAR, clear_addr=0, commutator=0, all branch pointers=0, out_valid=0, out_data=0, sync_err=0, in_ready=0. A reset asserted mid-stream aborts everything and restarts CLEAR.
- FSM CLEAR: writes 0 to RAM[clear_addr] each cycle, increments clear_addr; after DEPTH-1 is written, goes to RUN. in_ready=0 for exactly DEPTH cycles after reset deasserts.
- FSM RUN: in_ready=1. Accept occurs when in_valid&&in_ready; no accept means no state change (commutator and pointers hold, out_valid=0).
- Branch select: b = (in_sync && commutator!=0) ? 0 : commutator. On a realignment, sync_err=1 next cycle. in_sync with commutator==0 gives no error.
- After an accept, commutator = (b==I-1) ? 0 : b+1.
- Branch b<I-1: cell address = base[b] + ptr[b], where base[b] = M*(b*(2I-b-1)/2) is a constant table. The old cell content is read and in_data is written to the same cell; ptr[b] wraps at (I-1-b)*M-1 back to 0.
- Read-before-write on the same address, same cycle; RAM returns old data.
- Branch I-1: zero depth. in_data goes to the output register with no RAM access.
- Latency: out_valid/out_data are registered 1 cycle after the accept. A byte on branch j appears at the output of the accept (I-1-j)*M*I accepts later, plus 1 cycle. With an aligned interleaver the end-to-end delay is (I-1)*M*I = 2244 accepted bytes for the defaults.
- Outputs read from cells not yet written since CLEAR are 0.
- out_data holds its last value when out_valid=0.
- Widths: ptr per branch is clog2((I-1)*M) bits; RAM address is clog2(DEPTH) bits; all base/wrap constants are computed at elaboration.

Decomposition:
- Shared package `interleaver_pkg` holds:
  - I, M, W defaults;
  - DEPTH;
  - a function computing base[b] and branch length;
  - address width constants.
  The interleaver uses the same package.
- One sub-module: `deint_ram`, a single-port synchronous RAM of DEPTH x W with read-old-data-on-write. The top level holds the FSM, commutator, pointer array and output register.

Test Plan:
- Reset release with in_valid=1 held: in_ready=0 for exactly 1122 cycles, then 1. No out_valid during CLEAR.
- First accept after CLEAR, 0xA5 with in_sync=1 (branch 0): out_valid=1 next cycle with out_data=0x00. The 0xA5 reappears on the output of the accept 2244 accepts later.
- Send 11 zeros then 0x3C (branch 11): out_data=0x3C exactly 1 cycle after that accept.
- Loopback with the interleaver, counting bytes 0..255 repeating and in_sync every 204 bytes: after 2244 fill bytes the output equals the input sequence exactly, sync_err never asserts. Random in_valid gaps (~30%) give the identical output sequence.
- Assert in_sync when commutator=5: that byte goes to branch 0, sync_err pulses one cycle, and the next byte uses branch 1.
- Assert reset mid-stream after 3000 accepts: outputs go to 0 next cycle, CLEAR repeats for 1122 cycles, and post-clear outputs are 0 until refilled.

Source files
------------

// File: rtl/interleaver_pkg.sv
// Shared constants and elaboration-time helpers for the convolutional interleaver pair.
// Branch geometry is computed here so both sides agree on base addresses and depths.
package interleaver_pkg;

    localparam int unsigned DefI = 12;
    localparam int unsigned DefM = 17;
    localparam int unsigned DefW = 8;

    // Total cells for all branches: M * (0 + 1 + ... + (I-1)).
    function automatic int unsigned ram_depth(input int unsigned i, input int unsigned m);
        return m * i * (i - 1) / 2;
    endfunction

    function automatic int unsigned branch_len(input int unsigned i, input int unsigned m,
                                               input int unsigned b);
        return (i - 1 - b) * m;
    endfunction

    // Sum of the lengths of branches 0..b-1; b*(2i-b-1) is always even.
    function automatic int unsigned branch_base(input int unsigned i, input int unsigned m,
                                                input int unsigned b);
        return m * ((b * (2 * i - b - 1)) / 2);
    endfunction

    function automatic int unsigned addr_width(input int unsigned i, input int unsigned m);
        return $clog2(ram_depth(i, m));
    endfunction

    function automatic int unsigned ptr_width(input int unsigned i, input int unsigned m);
        return $clog2((i - 1) * m);
    endfunction

    localparam int unsigned Depth = ram_depth(DefI, DefM);
    localparam int unsigned AddrW = addr_width(DefI, DefM);

    typedef enum logic [0:0] {
        StClear,
        StRun
    } state_e;

endpackage

// File: rtl/deint_ram.sv
// Single-port synchronous RAM holding every deinterleaver branch FIFO.
// A read and a write to the same address in one cycle returns the old contents.
module deint_ram
    import interleaver_pkg::*;
#(
    parameter int unsigned Cells = Depth,
    parameter int unsigned AW    = AddrW,
    parameter int unsigned Width = DefW
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Cells];
    logic [Width-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_deinterleaver.sv
// Byte-wide Forney deinterleaver: commutator over I branches, branch j delays by (I-1-j)*M
// visits using a shared circular-buffer RAM that is zero-filled after every reset.
module conv_deinterleaver
    import interleaver_pkg::*;
#(
    parameter int unsigned I = DefI,
    parameter int unsigned M = DefM,
    parameter int unsigned W = DefW
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    input  logic         in_sync_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    output logic         sync_err_o
);

    localparam int unsigned Cells = ram_depth(I, M);
    localparam int unsigned AW    = addr_width(I, M);
    localparam int unsigned PW    = ptr_width(I, M);
    localparam int unsigned CW    = $clog2(I);
    localparam logic [CW-1:0] LastB = CW'(I - 1);

    state_e        state_q;
    logic [AW-1:0] clear_q;
    logic [CW-1:0] comm_q, comm_d;
    logic [PW-1:0] ptr_q [I];
    logic [PW-1:0] ptr_d [I];
    logic [AW-1:0] base_tbl [I];
    logic [PW-1:0] wrap_tbl [I];

    logic          out_valid_q;
    logic          sync_err_q;
    logic          sel_ram_q;
    logic [W-1:0]  byp_q;

    logic          clearing;
    logic          accept;
    logic          realign;
    logic [CW-1:0] branch;
    logic          ram_branch;
    logic [AW-1:0] acc_addr;
    logic          ram_we, ram_re;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_wdata, ram_rdata;

    // Entry I-1 of wrap_tbl is never consulted: the last branch bypasses the RAM.
    for (genvar gb = 0; gb < I; gb++) begin : g_tbl
        assign base_tbl[gb] = AW'(branch_base(I, M, gb));
        assign wrap_tbl[gb] = PW'(branch_len(I, M, gb) - 1);
    end

    assign clearing   = (state_q == StClear);
    assign accept     = in_valid_i && (state_q == StRun) && !reset_i;
    assign realign    = in_sync_i && (comm_q != '0);
    assign branch     = realign ? '0 : comm_q;
    assign ram_branch = (branch != LastB);
    assign acc_addr   = base_tbl[branch] + AW'(ptr_q[branch]);

    always_comb begin
        comm_d = comm_q;
        ptr_d  = ptr_q;
        if (accept) begin
            comm_d = ram_branch ? branch + CW'(1) : '0;
            if (ram_branch) begin
                ptr_d[branch] = (ptr_q[branch] == wrap_tbl[branch]) ? '0
                                                                    : ptr_q[branch] + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StClear;
            clear_q <= '0;
        end else begin
            unique case (state_q)
                StClear: begin
                    if (clear_q == AW'(Cells - 1)) begin
                        state_q <= StRun;
                    end else begin
                        clear_q <= clear_q + AW'(1);
                    end
                end
                StRun: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            comm_q      <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            sel_ram_q   <= 1'b0;
            byp_q       <= '0;
            for (int b = 0; b < I; b++) begin
                ptr_q[b] <= '0;
            end
        end else begin
            comm_q      <= comm_d;
            ptr_q       <= ptr_d;
            out_valid_q <= accept;
            sync_err_q  <= accept && realign;
            if (accept) begin
                sel_ram_q <= ram_branch;
                if (!ram_branch) begin
                    byp_q <= in_data_i;
                end
            end
        end
    end

    // Clear writes zeros; in RUN the accepted byte replaces the cell whose old value is output.
    assign ram_we    = clearing || (accept && ram_branch);
    assign ram_re    = accept && ram_branch;
    assign ram_addr  = clearing ? clear_q : acc_addr;
    assign ram_wdata = clearing ? '0 : in_data_i;

    deint_ram #(
        .Cells (Cells),
        .AW    (AW),
        .Width (W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // Both sources only change on an accept, so the output holds between valid pulses.
    assign out_data_o  = sel_ram_q ? ram_rdata : byp_q;
    assign out_valid_o = out_valid_q;
    assign sync_err_o  = sync_err_q;
    assign in_ready_o  = (state_q == StRun);

endmodule
